// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush sequencer with saturating mispredict and stall-cycle counters
module pipeline_hazard_controller #(
  parameter int FLUSH_CYCLES = 2,
  parameter int COUNTER_WIDTH = 16,
  parameter logic HIGH = 1'b1,
  parameter logic LOW = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic PC_MISPREDICT_SELECT,
  input  logic INSTRUCTION_CACHE_READY,
  input  logic DATA_ACCESS,
  input  logic DATA_CACHE_READY,
  input  logic LOAD_USE_HAZARD,
  output logic STALL_PROGRAME_COUNTER_STAGE,
  output logic STALL_INSTRUCTION_FETCH,
  output logic STALL_DECODING,
  output logic STALL_EXECUTION,
  output logic CLEAR_INSTRUCTION_FETCH,
  output logic CLEAR_DECODING,
  output logic CLEAR_EXECUTION,
  output logic [COUNTER_WIDTH-1:0] MISPREDICT_COUNT,
  output logic [COUNTER_WIDTH-1:0] STALL_COUNT
);
  typedef enum logic [1:0] {RUN, FLUSH, IWAIT, DWAIT} state_t;
  state_t state, state_n;
  logic [3:0] flush_cnt, flush_cnt_n;
  logic d, m, i, l;
  assign d = DATA_ACCESS & ~DATA_CACHE_READY;
  assign m = PC_MISPREDICT_SELECT;
  assign i = ~INSTRUCTION_CACHE_READY;
  assign l = LOAD_USE_HAZARD;
  always_comb begin
    STALL_PROGRAME_COUNTER_STAGE = LOW;
    STALL_INSTRUCTION_FETCH = LOW;
    STALL_DECODING = LOW;
    STALL_EXECUTION = LOW;
    CLEAR_INSTRUCTION_FETCH = LOW;
    CLEAR_DECODING = LOW;
    CLEAR_EXECUTION = LOW;
    state_n = state;
    flush_cnt_n = flush_cnt;
    if (RST) begin
      CLEAR_INSTRUCTION_FETCH = HIGH;
      CLEAR_DECODING = HIGH;
      CLEAR_EXECUTION = HIGH;
    end else if (d) begin
      STALL_PROGRAME_COUNTER_STAGE = HIGH;
      STALL_INSTRUCTION_FETCH = HIGH;
      STALL_DECODING = HIGH;
      STALL_EXECUTION = HIGH;
      state_n = (state == FLUSH) ? FLUSH : DWAIT;
    end else if (m) begin
      CLEAR_INSTRUCTION_FETCH = HIGH;
      CLEAR_DECODING = HIGH;
      state_n = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
      flush_cnt_n = 4'(FLUSH_CYCLES - 1);
    end else if (state == FLUSH) begin
      CLEAR_INSTRUCTION_FETCH = HIGH;
      CLEAR_DECODING = HIGH;
      flush_cnt_n = flush_cnt - 4'd1;
      state_n = (flush_cnt <= 4'd1) ? RUN : FLUSH;
    end else if (i) begin
      STALL_PROGRAME_COUNTER_STAGE = HIGH;
      STALL_INSTRUCTION_FETCH = HIGH;
      CLEAR_DECODING = HIGH;
      state_n = (state == DWAIT) ? RUN : IWAIT;
    end else if (l && state != IWAIT) begin
      STALL_PROGRAME_COUNTER_STAGE = HIGH;
      STALL_INSTRUCTION_FETCH = HIGH;
      STALL_DECODING = HIGH;
      CLEAR_EXECUTION = HIGH;
      state_n = RUN;
    end else begin
      state_n = RUN;
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= RUN;
      flush_cnt <= '0;
      MISPREDICT_COUNT <= '0;
      STALL_COUNT <= '0;
    end else begin
      state <= state_n;
      flush_cnt <= flush_cnt_n;
      MISPREDICT_COUNT <= MISPREDICT_COUNT + COUNTER_WIDTH'(m && !d && !(&MISPREDICT_COUNT));
      STALL_COUNT <= STALL_COUNT + COUNTER_WIDTH'(STALL_PROGRAME_COUNTER_STAGE && !(&STALL_COUNT));
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed scoreboard bench for the hazard sequencer
module tb_pipeline_hazard_controller;
  localparam int CW = 4;
  localparam logic [4:0] IDLE = 5'b01010, MP = 5'b11010, DM = 5'b01100, IM = 5'b00010;
  localparam logic [4:0] LU = 5'b01011, LD = 5'b01101, MI = 5'b10010;
  localparam logic [6:0] ZR = 7'b0000000, CL = 7'b0000110, ST = 7'b1111000;
  localparam logic [6:0] IS = 7'b1100010, LS = 7'b1110001, RS = 7'b0000111;
  logic CLK = 1'b0, RST = 1'b1;
  logic m = 1'b0, icr = 1'b1, da = 1'b0, dcr = 1'b1, l = 1'b0;
  logic spc, sif, sid, sex, cif, cid, cex;
  logic [CW-1:0] mc, sc;
  logic [6:0] obs;
  logic [6:0] exp_q[$];
  int total = 0, passed = 0;
  pipeline_hazard_controller #(.FLUSH_CYCLES(2), .COUNTER_WIDTH(CW)) dut (
    .CLK(CLK), .RST(RST), .PC_MISPREDICT_SELECT(m), .INSTRUCTION_CACHE_READY(icr),
    .DATA_ACCESS(da), .DATA_CACHE_READY(dcr), .LOAD_USE_HAZARD(l),
    .STALL_PROGRAME_COUNTER_STAGE(spc), .STALL_INSTRUCTION_FETCH(sif),
    .STALL_DECODING(sid), .STALL_EXECUTION(sex), .CLEAR_INSTRUCTION_FETCH(cif),
    .CLEAR_DECODING(cid), .CLEAR_EXECUTION(cex), .MISPREDICT_COUNT(mc), .STALL_COUNT(sc)
  );
  always #5 CLK = ~CLK;
  assign obs = {spc, sif, sid, sex, cif, cid, cex};
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    assert (got === want) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
  endtask
  task automatic step(input string tag, input logic [4:0] in, input logic [6:0] e);
    {m, icr, da, dcr, l} = in;
    exp_q.push_back(e);
    @(negedge CLK);
    if (exp_q.size() == 0) chk({tag, "_noexp"}, 16'(obs), 16'hffff);
    else chk(tag, 16'(obs), 16'(exp_q.pop_front()));
    @(posedge CLK);
    #1;
  endtask
  task automatic pulse_rst();
    RST = 1'b1;
    #2;
    RST = 1'b0;
  endtask
  initial begin
    #1;
    for (int k = 0; k < 3; k++) begin
      step("reset_out", 5'($urandom), RS);
      chk("reset_mc", 16'(mc), 16'd0);
      chk("reset_sc", 16'(sc), 16'd0);
    end
    RST = 1'b0;
    step("idle", IDLE, ZR);
    step("mp", MP, CL);
    step("mp_flush1", IDLE, CL);
    step("mp_run", IDLE, ZR);
    chk("mp_mc", 16'(mc), 16'd1);
    chk("mp_sc", 16'(sc), 16'd0);
    pulse_rst();
    step("fd_mp", MP, CL);
    for (int k = 0; k < 3; k++) step("fd_d", DM, ST);
    step("fd_resume", IDLE, CL);
    step("fd_run", IDLE, ZR);
    chk("fd_mc", 16'(mc), 16'd1);
    chk("fd_sc", 16'(sc), 16'd3);
    pulse_rst();
    for (int k = 0; k < 4; k++) step("im_miss", IM, IS);
    step("im_ready", IDLE, ZR);
    chk("im_sc", 16'(sc), 16'd4);
    step("im2_miss", IM, IS);
    step("im2_mp", MI, CL);
    step("im2_flush", IM, CL);
    step("im2_miss_run", IM, IS);
    step("im2_ready", IDLE, ZR);
    chk("im2_sc", 16'(sc), 16'd6);
    chk("im2_mc", 16'(mc), 16'd1);
    pulse_rst();
    step("lu", LU, LS);
    step("lu_after", IDLE, ZR);
    step("lu_d", LD, ST);
    step("lu_dwait_exit", IDLE, ZR);
    step("lu_imiss", IM, IS);
    step("lu_in_iwait", LU, ZR);
    step("lu_run", IDLE, ZR);
    chk("lu_sc", 16'(sc), 16'd3);
    pulse_rst();
    step("rf_mp", MP, CL);
    pulse_rst();
    step("rf_discard", IDLE, ZR);
    chk("rf_mc", 16'(mc), 16'd0);
    for (int k = 0; k < 20; k++) step("sat_d", DM, ST);
    chk("sat_sc", 16'(sc), 16'd15);
    step("sat_exit", IDLE, ZR);
    chk("sat_hold", 16'(sc), 16'd15);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage core.
- Drives STALL_PROGRAME_COUNTER_STAGE of the program-counter stage, plus stall/clear of the fetch, decode and execution pipeline registers.
- Inputs: mispredict redirect (PC_MISPREDICT_SELECT), instruction/data cache readiness, and decode-stage load-use hazard.
- Keeps saturating performance counters for mispredicts and stall cycles.

Parameters:
FLUSH_CYCLES, 2, cycles CLEAR_INSTRUCTION_FETCH/CLEAR_DECODING held after a mispredict (1..15)
COUNTER_WIDTH, 16, width of each performance counter
HIGH, 1'b1, logic high
LOW, 1'b0, logic low

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-high
PC_MISPREDICT_SELECT  input  1  execution stage redirects PC this cycle
INSTRUCTION_CACHE_READY  input  1  fetch data valid this cycle
DATA_ACCESS  input  1  execution/memory stage performing load/store
DATA_CACHE_READY  input  1  data access completes this cycle
LOAD_USE_HAZARD  input  1  decode operand depends on load in execution
STALL_PROGRAME_COUNTER_STAGE  output  1  hold pc_reg
STALL_INSTRUCTION_FETCH  output  1  hold fetch register
STALL_DECODING  output  1  hold decode register
STALL_EXECUTION  output  1  hold execution register
CLEAR_INSTRUCTION_FETCH  output  1  load bubble into fetch register
CLEAR_DECODING  output  1  load bubble into decode register
CLEAR_EXECUTION  output  1  load bubble into execution register
MISPREDICT_COUNT  output  COUNTER_WIDTH  mispredicts accepted
STALL_COUNT  output  COUNTER_WIDTH  cycles with STALL_PROGRAME_COUNTER_STAGE high

Behaviour:
- States: RUN, FLUSH, IWAIT, DWAIT. State, flush counter (4 bit) and performance counters are registers; all stall/clear outputs are combinational from state + inputs (same-cycle response).
- Reset (RST high, async): state RUN, flush counter 0, counters 0. While RST high: all STALL_* LOW, all CLEAR_* HIGH.
- Event priority, every state: D = DATA_ACCESS & !DATA_CACHE_READY > M = PC_MISPREDICT_SELECT > I = !INSTRUCTION_CACHE_READY > L = LOAD_USE_HAZARD.
- D, any state: all four STALL_* HIGH, all CLEAR_* LOW.
  - RUN/IWAIT -> DWAIT.
  - FLUSH stays FLUSH, flush counter holds.
  - DWAIT stays DWAIT.
- DWAIT with !D: outputs as RUN rules, same cycle; next state RUN, or FLUSH if M.
- M (no D), any state: PC stall LOW so the redirect loads. CLEAR_INSTRUCTION_FETCH and CLEAR_DECODING HIGH. MISPREDICT_COUNT +1.
  - FLUSH_CYCLES == 1: next state RUN.
  - Otherwise: next state FLUSH, counter = FLUSH_CYCLES-1. M in FLUSH reloads the counter.
- FLUSH (no D, no M): CLEAR_INSTRUCTION_FETCH and CLEAR_DECODING HIGH; counter -1; counter reaching 0 -> RUN. I and L ignored in FLUSH.
- I (no D/M) in RUN or IWAIT: STALL_PROGRAME_COUNTER_STAGE and STALL_INSTRUCTION_FETCH HIGH, CLEAR_DECODING HIGH; next state IWAIT.
- IWAIT with INSTRUCTION_CACHE_READY high (no D/M): no stalls; -> RUN.
- L (RUN only, no D/M/I): STALL_PROGRAME_COUNTER_STAGE, STALL_INSTRUCTION_FETCH, STALL_DECODING HIGH; CLEAR_EXECUTION HIGH; stays RUN (one bubble per cycle L is high).
- A register never sees STALL and CLEAR together; STALL wins only under D, which forces all CLEAR_* LOW.
- Counters saturate at all-ones; no wrap. STALL_COUNT increments on every cycle STALL_PROGRAME_COUNTER_STAGE is HIGH, RST excluded.
- RST mid-FLUSH/IWAIT/DWAIT: immediate return to RUN, pending flush discarded.

Test Plan:
- Reset: RST=1 for 3 cycles, toggle all inputs -> STALL_* 0, CLEAR_* 1, counters 0; RST=0 with idle inputs -> all outputs 0.
- Mispredict, FLUSH_CYCLES=2: PC_MISPREDICT_SELECT 1 for 1 cycle -> CLEAR_INSTRUCTION_FETCH/CLEAR_DECODING high exactly 2 cycles, PC stall 0 throughout, MISPREDICT_COUNT=1.
- Data miss during flush: M at cycle 0, D held cycles 1-3 -> all stalls high cycles 1-3, CLEAR_* low there; clears resume cycle 4 for 1 cycle, then RUN.
- I-cache miss 4 cycles then ready -> PC/fetch stalls and CLEAR_DECODING high 4 cycles, STALL_COUNT=4; M on cycle 2 of miss -> PC stall drops that cycle, FLUSH entered.
- Load-use: L high 1 cycle in RUN -> PC/fetch/decode stall + CLEAR_EXECUTION for exactly that cycle; L with simultaneous D -> D response only.
- Saturation: COUNTER_WIDTH=4, 20 stall cycles -> STALL_COUNT=15, holds.
